// File: rtl/sram_wait_model.sv
// sram_wait_model: cycle-accurate behavioural model of the external SRAM with a
// req/ready handshake and a programmable number of wait states.
//
// Build option: define SRAM_ADDR_CHECK_EN to raise sram_err alongside sram_ready
// when the latched address is outside DEPTH. Without it sram_err is tied to 0.
// Out-of-range writes are dropped and reads return zero in both builds.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   sram_req    request, sampled only in IDLE
//   sram_we_en  0 = write, 1 = read (sampled with sram_req)
//   sram_addr   word address (sampled with sram_req)
//   sram_dq     bidirectional data: write data in / read data out in DONE
//   sram_ready  one-cycle completion pulse (state DONE)
//   sram_err    out-of-range flag, only meaningful with sram_ready
module sram_wait_model #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sram_req,
  input  logic              sram_we_en,
  input  logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              sram_ready,
  output logic              sram_err
);

  localparam int         MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] WAIT8  = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic              op_rd;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_data;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] mem [DEPTH];

  // With zero wait states DONE is entered on the accepting edge itself, before
  // the latches hold the request, so the access uses the live inputs in IDLE.
  logic              idle;
  logic              acc_rd;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              acc_in_range;
  logic              op_in_range;
  logic              enter_done;

  assign idle         = (state == IDLE);
  assign acc_rd       = idle ? sram_we_en : op_rd;
  assign acc_addr     = idle ? sram_addr  : op_addr;
  assign acc_data     = idle ? sram_dq    : op_data;
  assign acc_in_range = 32'(acc_addr) < 32'(DEPTH);
  assign op_in_range  = 32'(op_addr)  < 32'(DEPTH);
  assign enter_done   = (state_nxt == DONE) && (state != DONE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (sram_req) begin
        cnt_nxt   = WAIT8;
        state_nxt = (WAIT8 == 8'd0) ? DONE : BUSY;
      end
      BUSY: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt <= 8'd1) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_rd   <= 1'b0;
      op_addr <= '0;
      op_data <= '0;
      rd_data <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (idle && sram_req) begin
        op_rd   <= sram_we_en;
        op_addr <= sram_addr;
        if (!sram_we_en) op_data <= sram_dq;
      end
      if (enter_done && acc_rd)
        rd_data <= acc_in_range ? mem[acc_addr[MEM_AW-1:0]] : '0;
    end
  end

  // Memory is not reset; gating with rst keeps an access that is being
  // aborted by reset from committing.
  always_ff @(posedge clk) begin
    if (rst && enter_done && !acc_rd && acc_in_range)
      mem[acc_addr[MEM_AW-1:0]] <= acc_data;
  end

  assign sram_dq    = (state == DONE && op_rd) ? rd_data : 'z;
  assign sram_ready = (state == DONE);

`ifdef SRAM_ADDR_CHECK_EN
  assign sram_err = (state == DONE) && !op_in_range;
`else
  assign sram_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_wait_model.sv
// Testbench for sram_wait_model: one instance with WAIT_CYCLES=5 and one with
// WAIT_CYCLES=0 share the stimulus; 'sel' picks which one receives requests.
module tb_sram_wait_model;

`ifdef SRAM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we_en, sel;
  logic [15:0] addr;
  logic        tb_oe;
  logic [31:0] tb_val;
  wire  [31:0] dq5, dq0;
  logic        ready5, err5, ready0, err0;
  logic        req5, req0;

  int errors = 0;
  int checks = 0;

  // reference memories: address -> last committed data
  logic [31:0] mdl5 [int];
  logic [31:0] mdl0 [int];

  always #5 clk = ~clk;

  assign dq5  = tb_oe ? tb_val : 'z;
  assign dq0  = tb_oe ? tb_val : 'z;
  assign req5 = sel ? 1'b0 : req;
  assign req0 = sel ? req  : 1'b0;

  wire        rdy    = sel ? ready0 : ready5;
  wire        err    = sel ? err0   : err5;
  wire [31:0] dq_obs = sel ? dq0    : dq5;

  sram_wait_model #(.DATA_W(32), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(5)) u_dut5 (
    .clk(clk), .rst(rst), .sram_req(req5), .sram_we_en(we_en), .sram_addr(addr),
    .sram_dq(dq5), .sram_ready(ready5), .sram_err(err5));

  sram_wait_model #(.DATA_W(32), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .sram_req(req0), .sram_we_en(we_en), .sram_addr(addr),
    .sram_dq(dq0), .sram_ready(ready0), .sram_err(err0));

  function automatic int wc();
    return sel ? 0 : 5;
  endfunction

  // One complete access on the selected instance, checked against the model.
  task automatic do_op(input bit rd, input logic [15:0] a, input logic [31:0] d);
    int w;
    int cnt;
    bit got, known, oor, exp_err;
    logic [31:0] exp;
    w       = wc();
    oor     = (a >= 16'd1024);
    exp_err = CHK && oor;
    known   = 1'b1;
    exp     = '0;
    if (!oor) begin
      if (sel && mdl0.exists(int'(a)))       exp = mdl0[int'(a)];
      else if (!sel && mdl5.exists(int'(a))) exp = mdl5[int'(a)];
      else known = 1'b0;
    end
    @(negedge clk);
    req = 1'b1; we_en = rd; addr = a;
    tb_oe  = !rd || (w > 0);
    tb_val = rd ? $urandom : d;
    @(posedge clk);
    cnt = 0; got = 1'b0;
    while (!got && cnt < w + 4) begin
      @(negedge clk);
      cnt++;
      req  = 1'b0;
      addr = 16'($urandom);
      if (rdy === 1'b1) begin
        got = 1'b1;
        checks++;
        if (cnt != w + 1) begin
          errors++; $display("FAIL latency w=%0d: got %0d edges, want %0d", w, cnt, w + 1);
        end
        checks++;
        if (err !== exp_err) begin
          errors++; $display("FAIL err_done addr=%h: got %b, want %b", a, err, exp_err);
        end
        if (rd && known) begin
          checks++;
          if (dq_obs !== exp) begin
            errors++; $display("FAIL rd_data addr=%h: got %h, want %h", a, dq_obs, exp);
          end
        end
        if (!rd) begin
          checks++;
          if (dq_obs !== tb_val) begin
            errors++; $display("FAIL wr_done_nodrive: got %h, want %h", dq_obs, tb_val);
          end
        end
      end else begin
        checks++;
        if (err !== 1'b0) begin
          errors++; $display("FAIL err_busy: got %b, want 0", err);
        end
        if (tb_oe) begin
          checks++;
          if (dq_obs !== tb_val) begin
            errors++; $display("FAIL busy_nodrive: got %h, want %h", dq_obs, tb_val);
          end
        end
        // bus noise in BUSY must be ignored; release before a read's DONE
        if (rd && cnt >= w) tb_oe = 1'b0;
        else tb_val = $urandom;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ready_timeout addr=%h: got none, want pulse", a);
    end
    @(negedge clk);
    checks++;
    if (rdy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL ready_pulse_width: got rdy=%b err=%b, want 0 0", rdy, err);
    end
    tb_oe = 1'b0;
    if (!rd && !oor) begin
      if (sel) mdl0[int'(a)] = d;
      else     mdl5[int'(a)] = d;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 1'b0; we_en = 1'b1; addr = '0; tb_oe = 1'b0; tb_val = '0; sel = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ready5 !== 1'b0 || ready0 !== 1'b0 || err5 !== 1'b0 || err0 !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got r5=%b r0=%b e5=%b e0=%b, want all 0", ready5, ready0, err5, err0);
      end
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    sel = 1'b0;
    do_op(1'b0, 16'h0010, 32'hDEADBEEF);
    do_op(1'b1, 16'h0010, '0);
  endtask

  task automatic test_wait0();
    sel = 1'b1;
    do_op(1'b0, 16'h0003, 32'h12345678);
    do_op(1'b1, 16'h0003, '0);
  endtask

  // req held high: accepts only in IDLE, so ready recurs every w+2 cycles
  task automatic test_back_to_back(input bit s);
    int w;
    bit exp_rdy;
    sel = s; w = wc();
    @(negedge clk);
    req = 1'b1; we_en = 1'b1; addr = 16'h0010; tb_oe = 1'b0;
    for (int i = 1; i <= 4 * (w + 2); i++) begin
      @(negedge clk);
      addr = addr ^ 16'h0001;
      exp_rdy = ((i % (w + 2)) == (w + 1));
      checks++;
      if (rdy !== exp_rdy) begin
        errors++; $display("FAIL spacing w=%0d cyc=%0d: got %b, want %b", w, i, rdy, exp_rdy);
      end
    end
    req = 1'b0;
    repeat (w + 3) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    sel = 1'b0;
    do_op(1'b0, 16'h0020, 32'hAAAA5555);
    @(negedge clk);
    req = 1'b1; we_en = 1'b0; addr = 16'h0020; tb_oe = 1'b1; tb_val = 32'h11111111;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ready5 !== 1'b0) begin
      errors++; $display("FAIL reset_mid_ready: got %b, want 0", ready5);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1; tb_oe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (ready5 !== 1'b0) begin
        errors++; $display("FAIL aborted_ready cyc=%0d: got %b, want 0", i, ready5);
      end
    end
    do_op(1'b1, 16'h0020, '0);
  endtask

  task automatic test_out_of_range();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_op(1'b0, 16'h0400, 32'hFFFFFFFF);
      do_op(1'b1, 16'h0400, '0);
      do_op(1'b1, 16'hFFFF, '0);
    end
  endtask

  task automatic test_random();
    logic [15:0] pool [8];
    pool[0] = 16'h0000; pool[1] = 16'h0001; pool[2] = 16'h0005; pool[3] = 16'h0007;
    pool[4] = 16'h03FE; pool[5] = 16'h03FF; pool[6] = 16'h0400; pool[7] = 16'h8001;
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom_range(0, 1));
      do_op(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait0();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_reset_abort();
    test_out_of_range();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
